// File: rtl/instr_encode.sv
// instr_encode
//   Encodes instruction fields into 16-bit words and writes them into the
//   instruction RAM. A session starts with a start pulse in IDLE. Encoded
//   words pass through a 4-entry FIFO, and each word is written to the RAM
//   at an incrementing address.
//
//   Encodings:
//     memory format   : {1, ls, rd, addr[10:0]}
//     register format : {0, op[5:0], rd, rs1, rs2}
//
// Ports
//   CLK, RESETn         clock; asynchronous active-low reset
//   start, base_addr    session start pulse (accepted in IDLE only) and first address
//   in_valid/in_ready   input handshake; in_last marks the final word
//   fmt_mem, ls, op,
//   rd, rs1, rs2, addr  instruction fields
//   RAMi_stall          the RAM cannot take a write this cycle
//   RAMi_wren/addr/data RAM write port; addr and data hold their values when idle
//   busy, done          session in progress; one-cycle end-of-session pulse
//   ovf, count          sticky address-wrap flag; saturating word count
//   state_dbg           current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 DONE)
//
// Handshake: a transfer happens on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on registered state, never on in_valid.
// The source keeps the fields stable while in_valid is high and not yet accepted.
module instr_encode (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  input  logic [10:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic        fmt_mem,
  input  logic        ls,
  input  logic [5:0]  op,
  input  logic [2:0]  rd,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic [10:0] addr,
  input  logic        RAMi_stall,
  output logic        RAMi_wren,
  output logic [10:0] RAMi_addr,
  output logic [15:0] RAMi_data,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [11:0] count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] STP_WORD = 16'h7E00;

  state_t      state, state_nxt;
  logic [15:0] fifo_mem [4];
  logic [1:0]  wr_idx, rd_idx;
  logic [2:0]  fifo_cnt;
  logic [10:0] ptr;
  logic [10:0] addr_hold;
  logic [15:0] data_hold;
  logic [15:0] enc_word;
  logic        fifo_full, fifo_empty;
  logic        push, pop, start_ok;

  assign enc_word   = fmt_mem ? {1'b1, ls, rd, addr} : {1'b0, op, rd, rs1, rs2};
  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign in_ready   = (state == S_LOAD) && !fifo_full;
  assign push       = in_valid && in_ready;
  // The FIFO is only ever non-empty in LOAD or DRAIN.
  // A reset empties it at once, so RAMi_wren drops at once as well.
  assign pop        = !fifo_empty && !RAMi_stall;
  assign start_ok   = start && (state == S_IDLE);

  // The write port is combinational in the write cycle. Between writes it
  // shows the last address and data that were written.
  assign RAMi_wren = pop;
  assign RAMi_addr = pop ? ptr : addr_hold;
  assign RAMi_data = pop ? fifo_mem[rd_idx] : data_hold;

  // FIFO storage. Its contents have no meaning unless fifo_cnt covers them,
  // so this memory has no reset.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_idx] <= enc_word;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_idx <= wr_idx + 2'd1;
      if (pop)  rd_idx <= rd_idx + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Address pointer, count, wrap flag and the held write-port values.
  // A start is only accepted in IDLE, where the FIFO is empty.
  // So start_ok and pop never occur in the same cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr       <= 11'd0;
      count     <= 12'd0;
      ovf       <= 1'b0;
      addr_hold <= 11'd0;
      data_hold <= 16'd0;
    end else if (start_ok) begin
      ptr   <= base_addr;
      count <= 12'd0;
      ovf   <= 1'b0;
    end else if (pop) begin
      ptr       <= ptr + 11'd1;
      addr_hold <= ptr;
      data_hold <= fifo_mem[rd_idx];
      if (ptr == 11'h7FF)  ovf   <= 1'b1;
      if (count != 12'hFFF) count <= count + 12'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_LOAD;
      S_LOAD:  if (push && (in_last || enc_word == STP_WORD)) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state == S_LOAD) || (state == S_DRAIN);
    done      = (state == S_DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_instr_encode.sv
// Testbench for instr_encode.
// Encoded words come from field arithmetic. Each accepted word is predicted
// as a RAM write at a modelled address, and the observed writes are compared
// in order.
module tb_instr_encode;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic        fmt_mem = 1'b0;
  logic        ls = 1'b0;
  logic [5:0]  op = '0;
  logic [2:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [10:0] addr = '0;
  logic        RAMi_stall = 1'b0;
  logic        RAMi_wren;
  logic [10:0] RAMi_addr;
  logic [15:0] RAMi_data;
  logic        busy, done, ovf;
  logic [11:0] count;
  logic [1:0]  state_dbg;

  instr_encode dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .fmt_mem(fmt_mem), .ls(ls), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .addr(addr), .RAMi_stall(RAMi_stall), .RAMi_wren(RAMi_wren),
    .RAMi_addr(RAMi_addr), .RAMi_data(RAMi_data), .busy(busy), .done(done),
    .ovf(ovf), .count(count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [10:0] exp_a_q[$];
  logic [15:0] exp_q[$];
  logic [10:0] obs_a_q[$];
  logic [15:0] obs_d_q[$];
  int          m_ptr   = 0;
  int          m_count = 0;
  bit          m_ovf   = 0;
  bit          stop_stall;

  // Every write strobe seen at a falling edge is recorded.
  always @(negedge CLK) begin
    if (RAMi_wren === 1'b1) begin
      obs_a_q.push_back(RAMi_addr);
      obs_d_q.push_back(RAMi_data);
    end
  end

  // Reference encoding built from field weights.
  function automatic int model_encode(input int fmt_i, ls_i, op_i, rd_i, rs1_i, rs2_i, addr_i);
    if (fmt_i != 0) return 32768 + ls_i * 16384 + rd_i * 2048 + addr_i;
    return op_i * 512 + rd_i * 64 + rs1_i * 8 + rs2_i;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic begin_session(input logic [10:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge CLK); #1;
    start = 1'b0;
    base_addr = 11'($urandom);
    m_ptr = int'(b); m_count = 0; m_ovf = 0;
    exp_a_q.delete(); exp_q.delete(); obs_a_q.delete(); obs_d_q.delete();
  endtask

  task automatic send_word(input int fmt_i, ls_i, op_i, rd_i, rs1_i, rs2_i, addr_i, last_i);
    bit acc;
    int w;
    acc = 0;
    fmt_mem = fmt_i[0]; ls = ls_i[0]; op = op_i[5:0]; rd = rd_i[2:0];
    rs1 = rs1_i[2:0]; rs2 = rs2_i[2:0]; addr = addr_i[10:0]; in_last = last_i[0];
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (in_ready === 1'b1) begin acc = 1; break; end
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after 200 cycles, required 1", in_ready);
    end else begin
      w = model_encode(fmt_i, ls_i, op_i, rd_i, rs1_i, rs2_i, addr_i);
      exp_a_q.push_back(11'(m_ptr));
      exp_q.push_back(16'(w));
      m_ptr = (m_ptr + 1) % 2048;
      if (m_ptr == 0) m_ovf = 1;
      if (m_count < 4095) m_count++;
    end
  endtask

  // Random non-STP word. The don't-care fields of each format get random values too.
  task automatic send_rand(input int last_i);
    if ($urandom_range(0, 1) == 1)
      send_word(1, $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2047), last_i);
    else
      send_word(0, $urandom_range(0, 1), $urandom_range(0, 62), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2047), last_i);
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin seen = 1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({in_ready, RAMi_wren, busy, done, ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ready/wren/busy/done/ovf=%b required 00000",
               {in_ready, RAMi_wren, busy, done, ovf});
    end
    n_tests++;
    if (RAMi_addr !== 11'd0 || RAMi_data !== 16'd0 || count !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h data=%h count=%0d required 0", RAMi_addr, RAMi_data, count);
    end
    n_tests++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d required 0 (IDLE)", state_dbg);
    end
    RESETn = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: ready=%b busy=%b required 0 0", in_ready, busy);
    end
  endtask

  task automatic test_mem_format();
    bit seen;
    begin_session(11'h010);
    send_word(1, 0, 0, 3, 0, 0, 'h155, 1);
    @(negedge CLK);
    n_tests++;
    if (RAMi_wren !== 1'b1 || RAMi_addr !== 11'h010 || RAMi_data !== 16'h9955) begin
      n_fail++;
      $display("FAIL mem_latency: wren=%b addr=%h data=%h required 1 010 9955", RAMi_wren, RAMi_addr, RAMi_data);
    end
    wait_done(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL mem_done: done=0 required 1"); end
    n_tests++;
    if (count !== 12'(m_count)) begin
      n_fail++; $display("FAIL mem_count: got %0d required %0d", count, m_count);
    end
    n_tests++;
    if (obs_d_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL mem_nwrites: got %0d required %0d", obs_d_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_d_q.size()) begin
      n_tests++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_d_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mem_write[%0d]: got %h@%h required %h@%h", i, obs_d_q[i], obs_a_q[i], exp_q[i], exp_a_q[i]);
      end
    end
    @(negedge CLK);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL mem_done_pulse: done=%b busy=%b state=%0d required 0 0 0", done, busy, state_dbg);
    end
    n_tests++;
    if (RAMi_wren !== 1'b0 || RAMi_addr !== 11'h010 || RAMi_data !== 16'h9955) begin
      n_fail++;
      $display("FAIL mem_hold: wren=%b addr=%h data=%h required 0 010 9955", RAMi_wren, RAMi_addr, RAMi_data);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_stp();
    bit seen;
    begin_session(11'h100);
    send_word(0, 0, 28, 1, 2, 3, 0, 0);  // MUL
    send_word(0, 0, 63, 0, 0, 0, 0, 0);  // STP, in_last low
    @(negedge CLK);
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL stp_ready: ready=%b busy=%b required 0 1", in_ready, busy);
    end
    wait_done(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL stp_done: done=0 required 1"); end
    n_tests++;
    if (obs_d_q.size() != 2 || obs_d_q[0] !== 16'h3853 || obs_d_q[1] !== 16'h7E00) begin
      n_fail++; $display("FAIL stp_words: got %p required 3853 7e00", obs_d_q);
    end
    n_tests++;
    if (obs_a_q.size() != exp_a_q.size() || obs_a_q != exp_a_q) begin
      n_fail++; $display("FAIL stp_addrs: got %p required %p", obs_a_q, exp_a_q);
    end
    n_tests++;
    if (count !== 12'(m_count)) begin
      n_fail++; $display("FAIL stp_count: got %0d required %0d", count, m_count);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    bit seen;
    RAMi_stall = 1'b1;
    begin_session(11'h200);
    for (int i = 0; i < 4; i++) send_rand(0);
    @(negedge CLK);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: in_ready=%b required 0", in_ready); end
    n_tests++;
    if (obs_d_q.size() != 0) begin
      n_fail++; $display("FAIL bp_stalled_writes: got %0d writes required 0", obs_d_q.size());
    end
    @(posedge CLK); #1;
    RAMi_stall = 1'b0;
    send_rand(1);
    wait_done(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL bp_done: done=0 required 1"); end
    n_tests++;
    if (obs_d_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_nwrites: got %0d required %0d", obs_d_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_d_q.size()) begin
      n_tests++;
      if (obs_a_q[i] !== exp_a_q[i] || obs_d_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_write[%0d]: got %h@%h required %h@%h", i, obs_d_q[i], obs_a_q[i], exp_q[i], exp_a_q[i]);
      end
    end
    n_tests++;
    if (count !== 12'(m_count)) begin
      n_fail++; $display("FAIL bp_count: got %0d required %0d", count, m_count);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_wrap();
    bit seen;
    begin_session(11'h7FF);
    send_rand(0);
    send_rand(1);
    wait_done(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL wrap_done: done=0 required 1"); end
    n_tests++;
    if (obs_a_q.size() != 2 || obs_a_q[0] !== 11'h7FF || obs_a_q[1] !== 11'h000) begin
      n_fail++; $display("FAIL wrap_addrs: got %p required 7ff 000", obs_a_q);
    end
    n_tests++;
    if (obs_d_q != exp_q) begin
      n_fail++; $display("FAIL wrap_data: got %p required %p", obs_d_q, exp_q);
    end
    n_tests++;
    if (ovf !== m_ovf) begin n_fail++; $display("FAIL wrap_ovf: got %b required %b", ovf, m_ovf); end
    @(posedge CLK); #1;
  endtask

  task automatic test_ignored_start();
    bit seen;
    begin_session(11'h300);
    n_tests++;
    if (ovf !== 1'b0 || count !== 12'd0) begin
      n_fail++; $display("FAIL start_clears: ovf=%b count=%0d required 0 0", ovf, count);
    end
    send_rand(0);
    start = 1'b1; base_addr = 11'h555;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || count !== 12'd1) begin
      n_fail++; $display("FAIL ign_state: busy=%b ready=%b count=%0d required 1 1 1", busy, in_ready, count);
    end
    @(posedge CLK); #1;
    send_rand(0);
    send_rand(1);
    wait_done(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL ign_done: done=0 required 1"); end
    n_tests++;
    if (obs_a_q != exp_a_q || obs_d_q != exp_q) begin
      n_fail++; $display("FAIL ign_writes: got %p / %p required %p / %p", obs_a_q, obs_d_q, exp_a_q, exp_q);
    end
    n_tests++;
    if (count !== 12'(m_count)) begin
      n_fail++; $display("FAIL ign_count: got %0d required %0d", count, m_count);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    RAMi_stall = 1'b1;
    begin_session(11'h400);
    for (int i = 0; i < 3; i++) send_rand(0);
    obs_a_q.delete(); obs_d_q.delete();
    RAMi_stall = 1'b0;
    #1;
    n_tests++;
    if (RAMi_wren !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wren: got %b required 1", RAMi_wren); end
    #1;
    RESETn = 1'b0;
    #1;
    n_tests++;
    if (RAMi_wren !== 1'b0 || count !== 12'd0 || state_dbg !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: wren=%b count=%0d state=%0d busy=%b required 0 0 0 0", RAMi_wren, count, state_dbg, busy);
    end
    n_tests++;
    if (RAMi_addr !== 11'd0 || RAMi_data !== 16'd0) begin
      n_fail++; $display("FAIL rst_port: addr=%h data=%h required 0 0", RAMi_addr, RAMi_data);
    end
    @(posedge CLK); #1;
    RESETn = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    n_tests++;
    if (obs_d_q.size() != 0) begin
      n_fail++; $display("FAIL rst_no_writes: got %0d writes required 0", obs_d_q.size());
    end
    n_tests++;
    if (count !== 12'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: count=%0d busy=%b required 0 0", count, busy);
    end
  endtask

  task automatic test_random();
    bit seen;
    int len;
    bit use_stp;
    for (int s = 0; s < 12; s++) begin
      len     = $urandom_range(1, 8);
      use_stp = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin_session(11'($urandom_range(2040, 2047)));
      else                          begin_session(11'($urandom_range(0, 2047)));
      stop_stall = 0;
      seen = 0;
      fork
        begin
          while (!stop_stall) begin
            @(posedge CLK); #2;
            RAMi_stall = ($urandom_range(0, 2) == 0);
          end
        end
        begin
          for (int i = 0; i < len - 1; i++) send_rand(0);
          if (use_stp) send_word(0, 0, 63, 0, 0, 0, 0, 0);
          else         send_rand(1);
          wait_done(seen);
          stop_stall = 1;
        end
      join
      RAMi_stall = 1'b0;
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL rand%0d_done: done=0 required 1", s); end
      n_tests++;
      if (obs_a_q != exp_a_q || obs_d_q != exp_q) begin
        n_fail++; $display("FAIL rand%0d_writes: got %p / %p required %p / %p", s, obs_a_q, obs_d_q, exp_a_q, exp_q);
      end
      n_tests++;
      if (count !== 12'(m_count) || ovf !== m_ovf) begin
        n_fail++; $display("FAIL rand%0d_status: count=%0d ovf=%b required %0d %b", s, count, ovf, m_count, m_ovf);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_count_saturate();
    bit seen;
    int bad;
    bad = 0;
    begin_session(11'h000);
    for (int i = 0; i < 4097; i++) send_rand(i == 4096 ? 1 : 0);
    wait_done(seen);
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL sat_done: done=0 required 1"); end
    n_tests++;
    if (count !== 12'(m_count)) begin
      n_fail++; $display("FAIL sat_count: got %0d required %0d", count, m_count);
    end
    n_tests++;
    if (ovf !== m_ovf) begin n_fail++; $display("FAIL sat_ovf: got %b required %b", ovf, m_ovf); end
    n_tests++;
    if (obs_d_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sat_nwrites: got %0d required %0d", obs_d_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_d_q.size()) begin
      if (obs_a_q[i] !== exp_a_q[i] || obs_d_q[i] !== exp_q[i]) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL sat_writes: got %0d wrong writes required 0", bad);
    end
    @(posedge CLK); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mem_format();
    test_stp();
    test_backpressure();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_count_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
